eq_stream_monitor: RTL and testbench

//   Registered, handshaked downstream stage for the equality/inequality compare logic.
//   - Accepts operand pairs (a, b) and emits a registered result: eq, ne, diff bits.
//   - Tracks a run of consecutive matches in a lock FSM.
//   - Keeps saturating match/miss statistics for status reads and bench checking.

---
 rtl/eq_stream_monitor_if.sv | 39 +++
 rtl/eq_stream_monitor.sv | 127 ++++++++++++
 tb/tb_eq_stream_monitor.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_stream_monitor_if.sv
// Operand/result stream bundle for eq_stream_monitor.
// master drives operands and result back-pressure; slave is the compare stage.
interface eq_stream_monitor_if #(
  parameter int unsigned WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_eq;
  logic             out_ne;
  logic [WIDTH-1:0] out_diff;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_eq,
    input  out_ne,
    input  out_diff
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_eq,
    output out_ne,
    output out_diff
  );
endinterface

// File: rtl/eq_stream_monitor.sv
// Registered, handshaked equality compare stage with a match-run lock FSM
// and saturating match/miss statistics.
module eq_stream_monitor #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  eq_stream_monitor_if.slave bus,
  output logic               locked,
  output logic               lost,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  typedef enum logic [1:0] {
    StSearch,
    StLocked,
    StLost
  } state_e;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [8:0]       LockCount = 9'(LOCK_COUNT);

  state_e     state_q;
  logic [7:0] run_q;
  logic       accept;
  logic       is_match;
  logic [8:0] run_inc;

  // Full-throughput handshake: a draining result frees the register this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_match     = (bus.in_a == bus.in_b);
  assign run_inc      = {1'b0, run_q} + 9'd1;

  // Result register; clear deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_eq    <= 1'b0;
      bus.out_ne    <= 1'b0;
      bus.out_diff  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_eq    <= is_match;
      bus.out_ne    <= !is_match;
      bus.out_diff  <= bus.in_a ^ bus.in_b;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (clear) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (accept) begin
      if (is_match && (match_cnt != CntMax)) begin
        match_cnt <= match_cnt + CntOne;
      end
      if (!is_match && (miss_cnt != CntMax)) begin
        miss_cnt <= miss_cnt + CntOne;
      end
    end
  end

  // Lock FSM with registered locked/lost; lost is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSearch;
      run_q   <= '0;
      locked  <= 1'b0;
      lost    <= 1'b0;
    end else if (clear) begin
      state_q <= StSearch;
      run_q   <= '0;
      locked  <= 1'b0;
      lost    <= 1'b0;
    end else begin
      lost <= 1'b0;
      if (accept) begin
        case (state_q)
          StSearch: begin
            if (!is_match) begin
              run_q <= '0;
            end else if (run_inc == LockCount) begin
              state_q <= StLocked;
              run_q   <= '0;
              locked  <= 1'b1;
            end else begin
              run_q <= run_inc[7:0];
            end
          end
          StLocked: begin
            if (!is_match) begin
              state_q <= StLost;
              locked  <= 1'b0;
              lost    <= 1'b1;
            end
          end
          StLost: begin
            if (is_match) begin
              state_q <= StLocked;
              locked  <= 1'b1;
            end else begin
              state_q <= StSearch;
              run_q   <= '0;
            end
          end
          default: begin
            state_q <= StSearch;
            run_q   <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eq_stream_monitor.sv
// Scoreboarded bench for eq_stream_monitor: directed scenarios plus randomized traffic
// checked against a behavioural model; a second instance uses 2-bit counters.
module tb_eq_stream_monitor;
  localparam int unsigned WIDTH      = 5;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned CNT_W_S    = 2;

  localparam int ModeSearch = 0;
  localparam int ModeLocked = 1;
  localparam int ModeLost   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic locked, lost, locked_s, lost_s;
  logic [CNT_W-1:0]   match_cnt, miss_cnt;
  logic [CNT_W_S-1:0] match_cnt_s, miss_cnt_s;

  eq_stream_monitor_if #(.WIDTH(WIDTH)) bus ();
  eq_stream_monitor_if #(.WIDTH(WIDTH)) bus_s ();

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_a      = bus.in_a;
  assign bus_s.in_b      = bus.in_b;
  assign bus_s.out_ready = bus.out_ready;

  eq_stream_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .locked    (locked),
    .lost      (lost),
    .match_cnt (match_cnt),
    .miss_cnt  (miss_cnt)
  );

  eq_stream_monitor #(.WIDTH(WIDTH), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W_S)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus_s),
    .locked    (locked_s),
    .lost      (lost_s),
    .match_cnt (match_cnt_s),
    .miss_cnt  (miss_cnt_s)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  typedef struct packed {
    logic             eq;
    logic [WIDTH-1:0] diff;
  } res_t;

  res_t        exp_q[$];
  int unsigned m_match, m_miss, m_run;
  int          m_mode;
  bit          m_lost;

  // Reference model: status checked every cycle, accepted pairs queued for the monitor.
  always @(negedge clk) begin
    if (rst) begin
      m_match = 0; m_miss = 0; m_run = 0; m_mode = ModeSearch; m_lost = 0;
      exp_q.delete();
    end else begin
      bit acc, m;
      check("locked", locked, m_mode == ModeLocked);
      check("lost", lost, m_lost);
      check("match_cnt", match_cnt, sat(m_match, (1 << CNT_W) - 1));
      check("miss_cnt", miss_cnt, sat(m_miss, (1 << CNT_W) - 1));
      check("locked_s", locked_s, m_mode == ModeLocked);
      check("match_cnt_s", match_cnt_s, sat(m_match, (1 << CNT_W_S) - 1));
      check("miss_cnt_s", miss_cnt_s, sat(m_miss, (1 << CNT_W_S) - 1));
      acc = bus.in_valid && bus.in_ready;
      m   = (bus.in_a == bus.in_b);
      if (acc) exp_q.push_back(res_t'{eq: m, diff: bus.in_a ^ bus.in_b});
      m_lost = 0;
      if (clear) begin
        m_match = 0; m_miss = 0; m_run = 0; m_mode = ModeSearch;
      end else if (acc) begin
        if (m) m_match++;
        else m_miss++;
        case (m_mode)
          ModeSearch: begin
            if (!m) m_run = 0;
            else if (m_run + 1 == LOCK_COUNT) begin m_mode = ModeLocked; m_run = 0; end
            else m_run++;
          end
          ModeLocked: if (!m) begin m_mode = ModeLost; m_lost = 1; end
          default: begin
            if (m) m_mode = ModeLocked;
            else begin m_mode = ModeSearch; m_run = 0; end
          end
        endcase
      end
    end
  end

  // Monitor: each result is compared once, when it is handed downstream.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL result_unexpected: got diff %0h with no pending pair (t=%0t)",
                 bus.out_diff, $time);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("out_eq", bus.out_eq, e.eq);
        check("out_ne", bus.out_ne, !e.eq);
        check("out_diff", bus.out_diff, e.diff);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.in_valid)
      assert (!$isunknown({bus.in_a, bus.in_b})) else $error("X/Z operand while in_valid");
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
  endtask

  initial begin
    int c0;
    bit pend;
    logic [WIDTH-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_eq", bus.out_eq, 0);
    check("rst_out_ne", bus.out_ne, 0);
    check("rst_out_diff", bus.out_diff, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_counts", {match_cnt, miss_cnt}, 0);
    check("rst_lock", {locked, lost}, 0);

    // Single mismatching pair
    send(5'b01010, 5'b00101);
    check("t2_valid", bus.out_valid, 1);
    check("t2_eq", bus.out_eq, 0);
    check("t2_ne", bus.out_ne, 1);
    check("t2_diff", bus.out_diff, 5'b01111);
    check("t2_miss", miss_cnt, 1);

    // Back-pressure hold, then full-throughput burst
    idle(1);
    bus.out_ready = 1'b0;
    send(5'h1f, 5'h1f);
    bus.in_valid = 1'b1;
    bus.in_a     = 5'h03;
    bus.in_b     = 5'h07;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_eq", bus.out_eq, 1);
      check("bp_out_diff", bus.out_diff, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    c0 = cyc;
    send(5'h03, 5'h07);
    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'(i * 3);
      rb = (i % 2 == 0) ? ra : ~ra;
      send(ra, rb);
    end
    check("burst_cycles", cyc - c0, 7);

    // Lock sequence
    pulse_clear();
    repeat (3) send(5'h05, 5'h05);
    check("lock_pre", locked, 0);
    send(5'h05, 5'h05);
    check("lock_on", {locked, lost}, 2'b10);
    send(5'h01, 5'h02);
    check("lock_lost", {locked, lost}, 2'b01);
    send(5'h09, 5'h09);
    check("lock_relock", {locked, lost}, 2'b10);
    send(5'h01, 5'h03);
    check("lock_lost2", {locked, lost}, 2'b01);
    send(5'h02, 5'h03);
    check("lock_search", {locked, lost}, 2'b00);
    repeat (3) send(5'h11, 5'h11);
    check("run_restart", locked, 0);
    send(5'h11, 5'h11);
    check("run_relock", locked, 1);

    // Saturation on the 2-bit instance, then clear racing an accept
    pulse_clear();
    repeat (5) send(5'h07, 5'h07);
    check("sat_small", match_cnt_s, 3);
    check("sat_wide", match_cnt, 5);
    clear = 1'b1;
    send(5'h04, 5'h04);
    clear = 1'b0;
    check("clr_match", match_cnt, 0);
    check("clr_match_s", match_cnt_s, 0);
    check("clr_locked", locked, 0);
    check("clr_out", {bus.out_valid, bus.out_eq}, 2'b11);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      pend = bus.in_valid && !bus.in_ready;
      @(posedge clk);
      #1;
      if (!pend) begin
        ra = WIDTH'($urandom);
        rb = ($urandom_range(3, 0) != 0) ? ra : WIDTH'($urandom);
        bus.in_valid = ($urandom_range(9, 0) < 7);
        bus.in_a     = ra;
        bus.in_b     = rb;
      end
      bus.out_ready = ($urandom_range(9, 0) < 7);
      clear         = ($urandom_range(99, 0) < 3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    clear         = 1'b0;
    idle(3);
    check("rand_drained", exp_q.size(), 0);

    // Reset while a result is stalled
    bus.out_ready = 1'b0;
    send(5'h06, 5'h06);
    #1;
    rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_counts", {match_cnt, miss_cnt}, 0);
    check("arst_lock", {locked, lost}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    idle(1);
    send(5'h01, 5'h01);
    check("post_rst_eq", bus.out_eq, 1);
    check("post_rst_match", match_cnt, 1);
    idle(2);
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
